pipe_mips32: RTL and testbench
==============================

// Module: pipe_mips32
// PURPOSE
//  5-stage pipelined MIPS32-subset CPU (IF, ID, EX, MEM, WB) with a unified word-addressed memory.
//  Top-level compute block: benches preload Mem[], Reg_bank[] and control regs hierarchically, then run.
//  Full operand forwarding, so back-to-back dependent instructions need no padding.
//  Retiring HLT stops execution.
// PARAMETERS
//  MEM_DEPTH  1024  number of 32-bit words in Mem[] (shared instruction/data); power of 2
//  XLEN       32    datapath, register and instruction width
// PORTS
//  clk     in   1  single clock; every state element updates on rising edge
//  rst     in   1  asynchronous, active-high reset
//  halted  out  1  mirrors internal HALTED
// BEHAVIOUR
//  Interface: one clock `clk`; reset `rst` is asynchronous and active-high.
//  Hierarchically visible state, names fixed:
//    Reg_bank[0:31] (32b), Mem[0:MEM_DEPTH-1] (32b), PC (32b), HALTED (1b), TAKEN_BRANCH (1b).
//  Reset: PC=0, HALTED=0, TAKEN_BRANCH=0, all pipeline registers hold NOP/invalid.
//    Reg_bank and Mem are NOT reset (preload survives). Mid-run reset: same, in-flight instrs discarded.
//  Encoding: op=[31:26], rs=[25:21], rt=[20:16], rd=[15:11], imm=[15:0] sign-extended.
//    RR (rd <- rs op rt): ADD 000000, SUB 000001, AND 000010, OR 000011, SLT 000100, MUL 000101.
//    RI (rt <- rs op imm): ADDI 001010, SUBI 001011, SLTI 001100.
//    LW 001000: rt <- Mem[rs+imm].  SW 001001: Mem[rs+imm] <- rt.
//    BNEZ 001101, BEQZ 001110: test rs; target = addr_of_branch + 1 + imm.
//    HLT 111111. Any other opcode executes as NOP.
//  Arithmetic: 32-bit wraparound, no overflow trap. SLT/SLTI signed compare giving 1/0.
//    MUL keeps the low 32 bits.
//  Memory: PC and LW/SW addresses are word indices; only the low log2(MEM_DEPTH) bits are used.
//    SW writes in MEM. Reads are combinational.
//  Register file:
//    R0 reads 0; writes to R0 are dropped.
//    WB writes on the clock edge; an ID read of the same register in that cycle returns the new value.
//  Forwarding: EX operands come from EX/MEM, then MEM/WB, then the ID value; youngest producer wins.
//  Load-use: an instruction needing a LW result in the very next slot stalls 1 cycle.
//    Stall = IF/ID held, bubble into EX.
//  Branch:
//    Resolved in EX. If taken: PC <- target, the 2 younger instrs (IF/ID, ID/EX) are squashed to NOP,
//    TAKEN_BRANCH = 1 for that cycle, else 0. Not-taken costs nothing.
//  HLT:
//    When HLT is decoded, fetch stops and PC freezes; bubbles are fed behind it.
//    Older instrs complete normally.
//    HLT in WB sets HALTED=1. While HALTED, no state changes except via rst.
//  Latency: ALU result is in Reg_bank 4 cycles after its fetch edge.
//    Program of N instrs ending in HLT sets HALTED at about cycle N+4.
// CONFIGURATION
//  MIPS32_MUL_EN defined: MUL (000101) implemented (32x32 -> low 32).
//  MIPS32_MUL_EN undefined: MUL decodes as NOP, rd unchanged.
// TESTING
//  1. Reg_bank[k]=k; Mem[0..8]={2801000a,28020014,28030019,0ce77800,0ce77800,00222000,0ce77800,00832800,fc000000}; rst pulse
//     -> after halted: R0=0 R1=10 R2=20 R3=25 R4=30 R5=55, R7=7.
//  2. Same program with both dummies at Mem[3..4] removed (forwarding) -> R4=30, R5=55.
//  3. Mem[120]=85; LW R2,0(R1) with R1=120; ADDI R2,R2,45; SW R2,1(R1); HLT
//     -> 1-cycle stall; Mem[121]=130.
//  4. Branch taken: BEQZ on R0 with imm=2 -> TAKEN_BRANCH pulses for 1 cycle; the next 2 instrs are skipped.
//     Same with BNEZ on R0 -> falls through, no pulse.
//  5. MUL R3,R1,R2 with R1=6, R2=7: with MIPS32_MUL_EN -> R3=42; without -> R3 unchanged.
//  6. Assert rst mid-program -> PC=0, HALTED=0 immediately, Reg_bank retained; program re-runs to the same result.

Source files
------------

// File: rtl/pipe_mips32.sv
// pipe_mips32: 5-stage (IF/ID/EX/MEM/WB) MIPS32-subset CPU with full forwarding and a 1-cycle load-use stall.
// Optional feature: define MIPS32_MUL_EN to implement MUL; otherwise MUL executes as a NOP.
module pipe_mips32 #(
    parameter int MEM_DEPTH = 1024,
    parameter int XLEN      = 32
) (
    input  logic clk,
    input  logic rst,
    output logic halted
);
    localparam int AW = $clog2(MEM_DEPTH);
    localparam logic [XLEN-1:0] ONE = 1;

    typedef enum logic [5:0] {
        OP_ADD  = 6'b000000,
        OP_SUB  = 6'b000001,
        OP_AND  = 6'b000010,
        OP_OR   = 6'b000011,
        OP_SLT  = 6'b000100,
        OP_MUL  = 6'b000101,
        OP_LW   = 6'b001000,
        OP_SW   = 6'b001001,
        OP_ADDI = 6'b001010,
        OP_SUBI = 6'b001011,
        OP_SLTI = 6'b001100,
        OP_BNEZ = 6'b001101,
        OP_BEQZ = 6'b001110,
        OP_HLT  = 6'b111111
    } opcode_t;

    // RR opcodes 0..5 map directly onto these codes.
    typedef enum logic [2:0] {
        ALU_ADD = 3'd0,
        ALU_SUB = 3'd1,
        ALU_AND = 3'd2,
        ALU_OR  = 3'd3,
        ALU_SLT = 3'd4,
        ALU_MUL = 3'd5
    } alu_t;

    typedef struct packed {
        alu_t            alu;
        logic            use_imm;
        logic            reg_write;
        logic            mem_read;
        logic            mem_write;
        logic            br_eqz;
        logic            br_nez;
        logic            halt;
        logic [4:0]      rs;
        logic [4:0]      rt;
        logic [4:0]      dest;
        logic [XLEN-1:0] a;
        logic [XLEN-1:0] b;
        logic [XLEN-1:0] imm;
        logic [XLEN-1:0] npc;
    } id_ex_t;

    typedef struct packed {
        logic            reg_write;
        logic            mem_read;
        logic            mem_write;
        logic            halt;
        logic [4:0]      dest;
        logic [XLEN-1:0] result;
        logic [XLEN-1:0] store;
    } ex_mem_t;

    typedef struct packed {
        logic            reg_write;
        logic            halt;
        logic [4:0]      dest;
        logic [XLEN-1:0] result;
    } mem_wb_t;

    logic [XLEN-1:0] Reg_bank [0:31];
    logic [XLEN-1:0] Mem [0:MEM_DEPTH-1];
    logic [XLEN-1:0] PC;
    logic            HALTED;
    logic            TAKEN_BRANCH;

    logic            fetch_stop;
    logic            if_id_valid;
    logic [XLEN-1:0] if_id_ir;
    logic [XLEN-1:0] if_id_npc;
    id_ex_t          id_ex;
    id_ex_t          dec;
    ex_mem_t         ex_mem;
    ex_mem_t         ex_next;
    mem_wb_t         mem_wb;
    mem_wb_t         wb_next;

    logic [5:0]      id_op;
    logic [4:0]      id_rs;
    logic [4:0]      id_rt;
    logic [4:0]      id_rd;
    logic [XLEN-1:0] id_a;
    logic [XLEN-1:0] id_b;
    logic            use_rs;
    logic            use_rt;
    logic            load_use;
    logic            id_halt;

    logic [XLEN-1:0] ex_a;
    logic [XLEN-1:0] ex_b;
    logic [XLEN-1:0] ex_y;
    logic [XLEN-1:0] ex_result;
    logic [XLEN-1:0] br_target;
    logic            br_taken;

    assign halted = HALTED;

    assign id_op = if_id_ir[31:26];
    assign id_rs = if_id_ir[25:21];
    assign id_rt = if_id_ir[20:16];
    assign id_rd = if_id_ir[15:11];

    // A register being written back this cycle is seen by ID immediately.
    assign id_a = (id_rs == 5'd0) ? '0 :
                  (mem_wb.reg_write && mem_wb.dest == id_rs) ? mem_wb.result : Reg_bank[id_rs];
    assign id_b = (id_rt == 5'd0) ? '0 :
                  (mem_wb.reg_write && mem_wb.dest == id_rt) ? mem_wb.result : Reg_bank[id_rt];

    // NOTE: every signal written here gets a default first so no latch is inferred.
    always_comb begin
        dec     = '0;
        dec.rs  = id_rs;
        dec.rt  = id_rt;
        dec.a   = id_a;
        dec.b   = id_b;
        dec.imm = {{(XLEN-16){if_id_ir[15]}}, if_id_ir[15:0]};
        dec.npc = if_id_npc;
        use_rs  = 1'b0;
        use_rt  = 1'b0;
        if (if_id_valid) begin
            case (id_op)
`ifdef MIPS32_MUL_EN
                OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT, OP_MUL: begin
`else
                OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT: begin
`endif
                    dec.alu       = alu_t'(id_op[2:0]);
                    dec.reg_write = 1'b1;
                    dec.dest      = id_rd;
                    use_rs        = 1'b1;
                    use_rt        = 1'b1;
                end
                OP_ADDI, OP_SUBI, OP_SLTI: begin
                    dec.alu       = (id_op == OP_ADDI) ? ALU_ADD :
                                    (id_op == OP_SUBI) ? ALU_SUB : ALU_SLT;
                    dec.use_imm   = 1'b1;
                    dec.reg_write = 1'b1;
                    dec.dest      = id_rt;
                    use_rs        = 1'b1;
                end
                OP_LW: begin
                    dec.use_imm   = 1'b1;
                    dec.mem_read  = 1'b1;
                    dec.reg_write = 1'b1;
                    dec.dest      = id_rt;
                    use_rs        = 1'b1;
                end
                OP_SW: begin
                    dec.use_imm   = 1'b1;
                    dec.mem_write = 1'b1;
                    use_rs        = 1'b1;
                    use_rt        = 1'b1;
                end
                OP_BNEZ: begin
                    dec.br_nez = 1'b1;
                    use_rs     = 1'b1;
                end
                OP_BEQZ: begin
                    dec.br_eqz = 1'b1;
                    use_rs     = 1'b1;
                end
                OP_HLT:  dec.halt = 1'b1;
                default: ;
            endcase
            // R0 is never a producer, so forwarding and stalls need no R0 special case.
            if (dec.dest == 5'd0) dec.reg_write = 1'b0;
        end
    end

    assign load_use = id_ex.mem_read && id_ex.reg_write &&
                      ((use_rs && id_ex.dest == id_rs) || (use_rt && id_ex.dest == id_rt));

    // Youngest producer wins: EX/MEM before MEM/WB before the value read in ID.
    always_comb begin
        ex_a = id_ex.a;
        if (ex_mem.reg_write && ex_mem.dest == id_ex.rs)      ex_a = ex_mem.result;
        else if (mem_wb.reg_write && mem_wb.dest == id_ex.rs) ex_a = mem_wb.result;
        ex_b = id_ex.b;
        if (ex_mem.reg_write && ex_mem.dest == id_ex.rt)      ex_b = ex_mem.result;
        else if (mem_wb.reg_write && mem_wb.dest == id_ex.rt) ex_b = mem_wb.result;
        ex_y = id_ex.use_imm ? id_ex.imm : ex_b;
        case (id_ex.alu)
            ALU_SUB: ex_result = ex_a - ex_y;
            ALU_AND: ex_result = ex_a & ex_y;
            ALU_OR:  ex_result = ex_a | ex_y;
            ALU_SLT: ex_result = {{(XLEN-1){1'b0}}, $signed(ex_a) < $signed(ex_y)};
`ifdef MIPS32_MUL_EN
            ALU_MUL: ex_result = ex_a * ex_y;
`endif
            default: ex_result = ex_a + ex_y;
        endcase
    end

    assign br_taken  = (id_ex.br_eqz && ex_a == '0) || (id_ex.br_nez && ex_a != '0);
    assign br_target = id_ex.npc + id_ex.imm;
    assign id_halt   = dec.halt && !br_taken;

    always_comb begin
        ex_next.reg_write = id_ex.reg_write;
        ex_next.mem_read  = id_ex.mem_read;
        ex_next.mem_write = id_ex.mem_write;
        ex_next.halt      = id_ex.halt;
        ex_next.dest      = id_ex.dest;
        ex_next.result    = ex_result;
        ex_next.store     = ex_b;
    end

    always_comb begin
        wb_next.reg_write = ex_mem.reg_write;
        wb_next.halt      = ex_mem.halt;
        wb_next.dest      = ex_mem.dest;
        wb_next.result    = ex_mem.mem_read ? Mem[ex_mem.result[AW-1:0]] : ex_mem.result;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            PC           <= '0;
            HALTED       <= 1'b0;
            TAKEN_BRANCH <= 1'b0;
            fetch_stop   <= 1'b0;
            if_id_valid  <= 1'b0;
            if_id_ir     <= '0;
            if_id_npc    <= '0;
            id_ex        <= '0;
            ex_mem       <= '0;
            mem_wb       <= '0;
        end else if (!HALTED) begin
            TAKEN_BRANCH <= br_taken;
            if (mem_wb.halt) HALTED <= 1'b1;
            mem_wb <= wb_next;
            ex_mem <= ex_next;
            id_ex  <= (br_taken || load_use) ? id_ex_t'('0) : dec;
            if (id_halt) fetch_stop <= 1'b1;

            if (br_taken) begin
                PC          <= br_target;
                if_id_valid <= 1'b0;
                if_id_ir    <= '0;
            end else if (load_use) begin
                // Hold IF/ID and PC; the bubble goes into ID/EX above.
            end else if (fetch_stop || id_halt) begin
                if_id_valid <= 1'b0;
                if_id_ir    <= '0;
            end else begin
                if_id_valid <= 1'b1;
                if_id_ir    <= Mem[PC[AW-1:0]];
                if_id_npc   <= PC + ONE;
                PC          <= PC + ONE;
            end
        end
    end

    // NOTE: Reg_bank and Mem deliberately have no reset so preloaded contents survive rst.
    always_ff @(posedge clk) begin
        if (!HALTED && mem_wb.reg_write) Reg_bank[mem_wb.dest] <= mem_wb.result;
        if (!HALTED && ex_mem.mem_write) Mem[ex_mem.result[AW-1:0]] <= ex_mem.store;
    end

endmodule

// File: tb/tb_pipe_mips32.sv
// Bench for pipe_mips32: directed programs with known results, then random programs
// compared against a sequential instruction-level interpreter.
module tb_pipe_mips32;
    localparam int DEPTH = 1024;
    localparam int AW    = 10;
    localparam int DBASE = 512;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic halted;

    pipe_mips32 #(.MEM_DEPTH(DEPTH), .XLEN(32)) dut (
        .clk    (clk),
        .rst    (rst),
        .halted (halted)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    logic [31:0] m_reg [32];
    logic [31:0] m_mem [DEPTH];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic put_mem(input int a, input logic [31:0] v);
        m_mem[a] = v;
        dut.Mem[a] <= v;
    endtask

    task automatic put_reg(input int r, input logic [31:0] v);
        m_reg[r] = v;
        dut.Reg_bank[r] <= v;
    endtask

    task automatic clear_all();
        rst = 1'b1;
        #1;
        for (int i = 0; i < DEPTH; i++) put_mem(i, 32'h0);
        for (int r = 0; r < 32; r++) put_reg(r, 32'(r));
    endtask

    task automatic load_prog(input logic [31:0] p[$]);
        foreach (p[i]) put_mem(i, p[i]);
    endtask

    task automatic run(input string tag, input int max_cyc, output int cyc, output int pulses);
        #1;
        @(negedge clk);
        rst    = 1'b0;
        cyc    = 0;
        pulses = 0;
        while (halted !== 1'b1 && cyc < max_cyc) begin
            @(posedge clk);
            #1;
            cyc++;
            if (dut.TAKEN_BRANCH === 1'b1) pulses++;
        end
        check({tag, "_halted"}, 32'(halted), 32'd1);
    endtask

    function automatic logic [31:0] rreg(input logic [4:0] r);
        return (r == 5'd0) ? 32'h0 : m_reg[r];
    endfunction

    task automatic wreg(input logic [4:0] r, input logic [31:0] v);
        if (r != 5'd0) m_reg[r] = v;
    endtask

    // Executes one instruction at a time in program order until HLT.
    task automatic model_run();
        logic [31:0] pc, nxt, ir, a, b, imm, ea;
        logic [5:0]  op;
        pc = 32'h0;
        for (int s = 0; s < 4096; s++) begin
            ir  = m_mem[pc[AW-1:0]];
            op  = ir[31:26];
            if (op == 6'h3f) break;
            a   = rreg(ir[25:21]);
            b   = rreg(ir[20:16]);
            imm = {{16{ir[15]}}, ir[15:0]};
            ea  = a + imm;
            nxt = pc + 32'd1;
            case (op)
                6'h00: wreg(ir[15:11], a + b);
                6'h01: wreg(ir[15:11], a - b);
                6'h02: wreg(ir[15:11], a & b);
                6'h03: wreg(ir[15:11], a | b);
                6'h04: wreg(ir[15:11], {31'h0, $signed(a) < $signed(b)});
`ifdef MIPS32_MUL_EN
                6'h05: wreg(ir[15:11], a * b);
`endif
                6'h0a: wreg(ir[20:16], a + imm);
                6'h0b: wreg(ir[20:16], a - imm);
                6'h0c: wreg(ir[20:16], {31'h0, $signed(a) < $signed(imm)});
                6'h08: wreg(ir[20:16], m_mem[ea[AW-1:0]]);
                6'h09: m_mem[ea[AW-1:0]] = b;
                6'h0d: if (a != 32'h0) nxt = pc + 32'd1 + imm;
                6'h0e: if (a == 32'h0) nxt = pc + 32'd1 + imm;
                default: ;
            endcase
            pc = nxt;
        end
    endtask

    task automatic compare_model(input string tag);
        for (int r = 0; r < 32; r++)
            check($sformatf("%s_r%0d", tag, r), dut.Reg_bank[r], m_reg[r]);
        for (int i = 0; i < 16; i++)
            check($sformatf("%s_m%0d", tag, DBASE + i), dut.Mem[DBASE + i], m_mem[DBASE + i]);
    endtask

    task automatic gen_random(input int n, output logic [31:0] p[$]);
        logic [5:0]  op;
        logic [4:0]  rs, rt, rd;
        logic [15:0] imm;
        int k, lim;
        p = {};
        for (int i = 0; i < n - 1; i++) begin
            rs  = 5'($urandom_range(0, 7));
            rt  = 5'($urandom_range(0, 7));
            rd  = 5'($urandom_range(0, 7));
            imm = 16'($urandom);
            k   = $urandom_range(0, 9);
            if (k <= 3) begin
                op = 6'($urandom_range(0, 5));
                p.push_back({op, rs, rt, rd, 11'h0});
            end else if (k <= 5) begin
                op = 6'h0a + 6'($urandom_range(0, 2));
                p.push_back({op, rs, rt, imm});
            end else if (k == 6) begin
                p.push_back({6'h08, 5'd0, rt, 16'(DBASE + $urandom_range(0, 15))});
            end else if (k == 7) begin
                p.push_back({6'h09, 5'd0, rt, 16'(DBASE + $urandom_range(0, 15))});
            end else if (k == 8) begin
                lim = n - 2 - i;
                if (lim > 2) lim = 2;
                op  = ($urandom_range(0, 1) == 1) ? 6'h0d : 6'h0e;
                p.push_back({op, rs, 5'd0, 16'($urandom_range(0, lim))});
            end else begin
                p.push_back({6'h10 + 6'($urandom_range(0, 7)), 26'($urandom)});
            end
        end
        p.push_back(32'hfc000000);
    endtask

    initial begin
        int cyc, pulses;
        logic [31:0] p[$];
        logic [31:0] t1[$];

        t1 = {32'h2801000a, 32'h28020014, 32'h28030019, 32'h0ce77800, 32'h0ce77800,
              32'h00222000, 32'h0ce77800, 32'h00832800, 32'hfc000000};

        #1;
        clear_all();
        #1;
        check("rst_pc", dut.PC, 32'h0);
        check("rst_halted", 32'(halted), 32'h0);
        check("rst_taken", 32'(dut.TAKEN_BRANCH), 32'h0);

        clear_all();
        load_prog(t1);
        run("t1", 200, cyc, pulses);
        check("t1_r0", dut.Reg_bank[0], 32'd0);
        check("t1_r1", dut.Reg_bank[1], 32'd10);
        check("t1_r2", dut.Reg_bank[2], 32'd20);
        check("t1_r3", dut.Reg_bank[3], 32'd25);
        check("t1_r4", dut.Reg_bank[4], 32'd30);
        check("t1_r5", dut.Reg_bank[5], 32'd55);
        check("t1_r7", dut.Reg_bank[7], 32'd7);
        check("t1_cycles", 32'(cyc), 32'd13);

        clear_all();
        p = {32'h2801000a, 32'h28020014, 32'h28030019, 32'h00222000,
             32'h0ce77800, 32'h00832800, 32'hfc000000};
        load_prog(p);
        run("t2", 200, cyc, pulses);
        check("t2_r4", dut.Reg_bank[4], 32'd30);
        check("t2_r5", dut.Reg_bank[5], 32'd55);
        check("t2_cycles", 32'(cyc), 32'd11);

        clear_all();
        put_reg(1, 32'd120);
        put_mem(120, 32'd85);
        p = {32'h20220000, 32'h2842002d, 32'h24220001, 32'hfc000000};
        load_prog(p);
        run("t3", 200, cyc, pulses);
        check("t3_mem121", dut.Mem[121], 32'd130);
        check("t3_r2", dut.Reg_bank[2], 32'd130);
        check("t3_cycles", 32'(cyc), 32'd9);

        clear_all();
        p = {32'h38000002, 32'h280a0001, 32'h280b0001, 32'h280c0001, 32'hfc000000};
        load_prog(p);
        run("t4beqz", 200, cyc, pulses);
        check("t4beqz_pulses", 32'(pulses), 32'd1);
        check("t4beqz_r10", dut.Reg_bank[10], 32'd10);
        check("t4beqz_r11", dut.Reg_bank[11], 32'd11);
        check("t4beqz_r12", dut.Reg_bank[12], 32'd1);

        clear_all();
        p = {32'h34000002, 32'h280a0001, 32'h280b0001, 32'h280c0001, 32'hfc000000};
        load_prog(p);
        run("t4bnez", 200, cyc, pulses);
        check("t4bnez_pulses", 32'(pulses), 32'd0);
        check("t4bnez_r10", dut.Reg_bank[10], 32'd1);
        check("t4bnez_r11", dut.Reg_bank[11], 32'd1);

        clear_all();
        put_reg(1, 32'd6);
        put_reg(2, 32'd7);
        p = {32'h14221800, 32'hfc000000};
        load_prog(p);
        run("t5", 200, cyc, pulses);
`ifdef MIPS32_MUL_EN
        check("t5_r3", dut.Reg_bank[3], 32'd42);
`else
        check("t5_r3", dut.Reg_bank[3], 32'd3);
`endif

        clear_all();
        load_prog(t1);
        #1;
        @(negedge clk);
        rst = 1'b0;
        repeat (6) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("t6_pc", dut.PC, 32'h0);
        check("t6_halted", 32'(halted), 32'h0);
        check("t6_r1_kept", dut.Reg_bank[1], 32'd10);
        run("t6", 200, cyc, pulses);
        check("t6_r4", dut.Reg_bank[4], 32'd30);
        check("t6_r5", dut.Reg_bank[5], 32'd55);
        check("t6_cycles", 32'(cyc), 32'd13);

        for (int t = 0; t < 6; t++) begin
            clear_all();
            for (int r = 0; r < 8; r++) put_reg(r, $urandom);
            for (int i = 0; i < 16; i++) put_mem(DBASE + i, $urandom);
            gen_random(24, p);
            load_prog(p);
            model_run();
            run($sformatf("rnd%0d", t), 400, cyc, pulses);
            compare_model($sformatf("rnd%0d", t));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
